// File: rtl/boot_rom_ctrl.sv
// Boot ROM bus controller: req/gnt/rvalid core port to CSN-gated ROM macro; optional lock via `BOOT_ROM_LOCK_EN.
// Latency: response 1+WAIT_STATES cycles after accept; back-to-back accepts when WAIT_STATES=0.
// Backpressure: gnt_o held low while the wait counter runs; no response-side backpressure.
module boot_rom_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
    parameter int          ROM_AW      = 10,
    parameter int          ROM_DEPTH   = 700,
    parameter int          WAIT_STATES = 0
) (
    input  logic              CLK,
    input  logic              RSTN,
`ifdef BOOT_ROM_LOCK_EN
    input  logic              lock_i,
`endif
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              rom_csn_o,
    output logic [ROM_AW-1:0] rom_a_o,
    input  logic [31:0]       rom_q_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0] WS = 2'(WAIT_STATES);

    state_t      state;
    logic [1:0]  wait_cnt;
    logic        resp_err;
    logic [31:0] offset;
    logic        in_range;
    logic        locked;
    logic        legal;
    logic        accept;
    logic        unused_ok;

`ifdef BOOT_ROM_LOCK_EN
    logic lock_q;

    // Sticky until reset; the accept in the setting cycle still sees it clear.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            lock_q <= 1'b0;
        end else if (lock_i) begin
            lock_q <= 1'b1;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // Addresses below the base wrap to a huge offset, so the depth test rejects them too.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = (addr_i >= BASE_ADDR) && ((offset >> 2) < 32'(ROM_DEPTH));
    assign legal    = !we_i && in_range && !locked;

    assign gnt_o  = req_i && RSTN && (wait_cnt == 2'd0);
    assign accept = gnt_o;

    assign rom_csn_o = !(accept && legal);
    assign rom_a_o   = (accept && legal) ? offset[ROM_AW+1:2] : '0;

    // ROM output holds while CSN is high, so the data is still valid after wait states.
    assign rdata_o = (rvalid_o && !err_o) ? rom_q_i : 32'h0;

    assign unused_ok = &{1'b0, be_i, wdata_i};

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state    <= ST_IDLE;
            wait_cnt <= 2'd0;
            resp_err <= 1'b0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        resp_err <= !legal;
                        if (WS == 2'd0) begin
                            state    <= ST_RESP;
                            rvalid_o <= 1'b1;
                            err_o    <= !legal;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WS;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 2'd1;
                    if (wait_cnt == 2'd1) begin
                        state    <= ST_RESP;
                        rvalid_o <= 1'b1;
                        err_o    <= resp_err;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule
